// File: rtl/memory_stage_ls.sv
`default_nettype none
// ============================================================================
// Module  : memory_stage_ls
// Brief   : MEM pipeline stage with sized little-endian loads/stores, internal
//           word-addressed data memory, misalignment detection, single-step
//           gating and a registered debug read port.
// Revision: 1.0 - initial release
// ============================================================================
module memory_stage_ls #(
  parameter int NB_DATA     = 32,
  parameter int NB_REGISTER = 5,
  parameter int MEM_DEPTH   = 256,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_exec_mode,
  input  logic                   i_step,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  input  logic [1:0]             i_mem_size,
  input  logic                   i_mem_unsigned,
  input  logic                   i_mem_to_reg,
  input  logic                   i_reg_write,
  input  logic                   i_halt,
  input  logic [NB_DATA-1:0]     i_alu_result,
  input  logic [NB_DATA-1:0]     i_write_data,
  input  logic [NB_REGISTER-1:0] i_rt_rd,
  input  logic [NB_DATA-1:0]     i_pc_4,
  input  logic [NB_MEM_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]     o_read_data,
  output logic [NB_DATA-1:0]     o_alu_result,
  output logic [NB_REGISTER-1:0] o_rt_rd,
  output logic [NB_DATA-1:0]     o_pc_4,
  output logic                   o_mem_to_reg,
  output logic                   o_reg_write,
  output logic                   o_halt,
  output logic                   o_misaligned,
  output logic                   o_error,
  output logic [NB_DATA-1:0]     o_dbg_data
);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;

  logic                   r_step_q;
  logic                   w_step_pulse;
  logic                   w_advance;
  logic [NB_MEM_ADDR-1:0] w_word_idx;
  logic [1:0]             w_lane;
  logic                   w_is_byte;
  logic                   w_is_half;
  logic                   w_is_word;
  logic                   w_misaligned;
  logic                   w_store;
  logic [3:0]             w_byte_en;
  logic [NB_DATA-1:0]     w_wlanes;
  logic [NB_DATA-1:0]     w_mem_word;
  logic [7:0]             w_byte_sel;
  logic [15:0]            w_half_sel;
  logic [NB_DATA-1:0]     w_load_ext;
  logic [NB_DATA-1:0]     w_load_data;
  logic                   w_load_fault;
  logic                   w_unused;

  logic [NB_DATA-1:0] r_mem [MEM_DEPTH];

  // Step requests are level signals; only their rising edge advances the stage.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_step_q <= 1'b0;
    end else begin
      r_step_q <= i_step;
    end
  end

  assign w_step_pulse = i_step & ~r_step_q;
  assign w_advance    = i_valid & (~i_exec_mode | w_step_pulse);

  assign w_word_idx = i_alu_result[NB_MEM_ADDR+1:2];
  assign w_lane     = i_alu_result[1:0];
  assign w_unused   = &{1'b0, i_alu_result[NB_DATA-1:NB_MEM_ADDR+2]};

  assign w_is_byte = (i_mem_size == c_SIZE_BYTE);
  assign w_is_half = (i_mem_size == c_SIZE_HALF);
  assign w_is_word = ~w_is_byte & ~w_is_half;

  assign w_misaligned = (i_mem_read | i_mem_write) &
                        ((w_is_half & w_lane[0]) | (w_is_word & (w_lane != 2'b00)));

  assign w_store = w_advance & i_mem_write & ~w_misaligned & ~i_reset;

  // Replicate the right-aligned store data onto every lane; the byte enables pick.
  always_comb begin
    w_byte_en = 4'b0000;
    w_wlanes  = i_write_data;
    if (w_is_byte) begin
      w_byte_en = 4'b0001 << w_lane;
      w_wlanes  = {4{i_write_data[7:0]}};
    end else if (w_is_half) begin
      w_byte_en = w_lane[1] ? 4'b1100 : 4'b0011;
      w_wlanes  = {2{i_write_data[15:0]}};
    end else begin
      w_byte_en = 4'b1111;
      w_wlanes  = i_write_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byte_en[b]) begin
          r_mem[w_word_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
        end
      end
    end
  end

  assign w_mem_word = r_mem[w_word_idx];

  always_comb begin
    w_byte_sel = w_mem_word[7:0];
    case (w_lane)
      2'b00:   w_byte_sel = w_mem_word[7:0];
      2'b01:   w_byte_sel = w_mem_word[15:8];
      2'b10:   w_byte_sel = w_mem_word[23:16];
      default: w_byte_sel = w_mem_word[31:24];
    endcase
  end

  assign w_half_sel = w_lane[1] ? w_mem_word[31:16] : w_mem_word[15:0];

  always_comb begin
    w_load_ext = w_mem_word;
    if (w_is_byte) begin
      w_load_ext = i_mem_unsigned ? {{(NB_DATA-8){1'b0}}, w_byte_sel}
                                  : {{(NB_DATA-8){w_byte_sel[7]}}, w_byte_sel};
    end else if (w_is_half) begin
      w_load_ext = i_mem_unsigned ? {{(NB_DATA-16){1'b0}}, w_half_sel}
                                  : {{(NB_DATA-16){w_half_sel[15]}}, w_half_sel};
    end
  end

  // A combined read+write returns nothing to WB; the store takes priority.
  assign w_load_data  = (i_mem_read & ~i_mem_write & ~w_misaligned) ? w_load_ext : '0;
  assign w_load_fault = i_mem_read & w_misaligned;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_rt_rd      <= '0;
      o_pc_4       <= '0;
      o_mem_to_reg <= 1'b0;
      o_reg_write  <= 1'b0;
      o_halt       <= 1'b0;
      o_misaligned <= 1'b0;
      o_error      <= 1'b0;
    end else if (w_advance) begin
      o_read_data  <= w_load_data;
      o_alu_result <= i_alu_result;
      o_rt_rd      <= i_rt_rd;
      o_pc_4       <= i_pc_4;
      o_mem_to_reg <= i_mem_to_reg & ~w_load_fault;
      o_reg_write  <= i_reg_write & ~w_load_fault;
      o_halt       <= i_halt;
      o_misaligned <= w_misaligned;
      o_error      <= o_error | w_misaligned;
    end
  end

  // Debug port sees the pre-write word when a store hits the same address.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_dbg_data <= '0;
    end else begin
      o_dbg_data <= r_mem[i_dbg_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage_ls.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_stage_ls
// Brief   : Self-checking bench for memory_stage_ls against a byte-array model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_memory_stage_ls;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_exec_mode, i_step, i_mem_read, i_mem_write;
  logic [1:0]  i_mem_size;
  logic        i_mem_unsigned, i_mem_to_reg, i_reg_write, i_halt;
  logic [31:0] i_alu_result, i_write_data, i_pc_4;
  logic [4:0]  i_rt_rd;
  logic [7:0]  i_dbg_addr;
  logic [31:0] o_read_data, o_alu_result, o_pc_4, o_dbg_data;
  logic [4:0]  o_rt_rd;
  logic        o_mem_to_reg, o_reg_write, o_halt, o_misaligned, o_error;

  always #5 clk = ~clk;

  memory_stage_ls #(.NB_DATA(32), .NB_REGISTER(5), .MEM_DEPTH(256), .NB_MEM_ADDR(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .i_exec_mode(i_exec_mode),
    .i_step(i_step), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned), .i_mem_to_reg(i_mem_to_reg),
    .i_reg_write(i_reg_write), .i_halt(i_halt), .i_alu_result(i_alu_result),
    .i_write_data(i_write_data), .i_rt_rd(i_rt_rd), .i_pc_4(i_pc_4), .i_dbg_addr(i_dbg_addr),
    .o_read_data(o_read_data), .o_alu_result(o_alu_result), .o_rt_rd(o_rt_rd),
    .o_pc_4(o_pc_4), .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
    .o_halt(o_halt), .o_misaligned(o_misaligned), .o_error(o_error), .o_dbg_data(o_dbg_data)
  );

  typedef struct {
    logic        v, mode, step, rd, wr;
    logic [1:0]  sz;
    logic        uns, regw, halt;
    logic [31:0] addr, wd, pc;
    logic [4:0]  rt;
    logic [7:0]  dbg;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_regw;
  } vec_t;

  int n_err = 0;
  int n_chk = 0;
  int pc_ctr = 0;

  // Reference model: byte-addressed memory plus the expected output registers
  logic [7:0]  mb [1024];
  logic        sq;
  logic [31:0] e_rdata, e_alu, e_pc, e_dbg;
  logic [4:0]  e_rt;
  logic        e_mis, e_regw, e_m2r, e_halt, e_err;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  function automatic instr_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    instr_t t;
    t.v = 1'b1; t.mode = 1'b0; t.step = 1'b0;
    t.rd = rd; t.wr = wr; t.sz = sz; t.uns = uns; t.regw = rd;
    t.halt = 1'($urandom); t.addr = addr; t.wd = wd;
    t.pc = 32'(pc_ctr); pc_ctr = pc_ctr + 4;
    t.rt = 5'($urandom); t.dbg = 8'($urandom);
    return t;
  endfunction

  task automatic model_reset();
    sq = 1'b0; e_rdata = '0; e_alu = '0; e_pc = '0; e_dbg = '0; e_rt = '0;
    e_mis = 1'b0; e_regw = 1'b0; e_m2r = 1'b0; e_halt = 1'b0; e_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, o_read_data, 32'h0);
    chk({tag, "_alu"},   o_alu_result, 32'h0);
    chk({tag, "_rt"},    32'(o_rt_rd), 32'h0);
    chk({tag, "_pc"},    o_pc_4, 32'h0);
    chk({tag, "_flags"}, {27'h0, o_mem_to_reg, o_reg_write, o_halt, o_misaligned, o_error}, 32'h0);
    chk({tag, "_dbg"},   o_dbg_data, 32'h0);
  endtask

  // Drive one cycle (called just after a falling edge), update model, check after the rising edge
  task automatic cyc(input instr_t t);
    int a, n;
    logic mis, adv;
    logic [31:0] ld;
    i_valid = t.v; i_exec_mode = t.mode; i_step = t.step; i_mem_read = t.rd;
    i_mem_write = t.wr; i_mem_size = t.sz; i_mem_unsigned = t.uns; i_mem_to_reg = t.rd;
    i_reg_write = t.regw; i_halt = t.halt; i_alu_result = t.addr; i_write_data = t.wd;
    i_rt_rd = t.rt; i_pc_4 = t.pc; i_dbg_addr = t.dbg;

    adv = t.v && (!t.mode || (t.step && !sq));
    sq  = t.step;
    e_dbg = mword(int'(t.dbg));
    if (adv) begin
      a   = int'(t.addr[9:0]);
      n   = (t.sz == 2'd0) ? 1 : (t.sz == 2'd1) ? 2 : 4;
      mis = (t.rd || t.wr) && ((a % n) != 0);
      ld  = '0;
      for (int k = 0; k < n; k++) ld = ld | (32'(mb[(a + k) % 1024]) << (8 * k));
      if (!t.uns && n < 4 && ld[8*n-1]) ld = ld | ~((32'h1 << (8 * n)) - 32'h1);
      if (!t.rd || t.wr || mis) ld = '0;
      if (t.wr && !mis) for (int k = 0; k < n; k++) mb[(a + k) % 1024] = t.wd[8*k +: 8];
      e_rdata = ld; e_mis = mis;
      e_regw = t.regw && !(mis && t.rd);
      e_m2r  = t.rd && !mis;
      e_alu = t.addr; e_rt = t.rt; e_pc = t.pc; e_halt = t.halt;
      e_err = e_err | mis;
    end

    @(posedge clk); #1;
    chk("read_data",  o_read_data, e_rdata);
    chk("misaligned", 32'(o_misaligned), 32'(e_mis));
    chk("reg_write",  32'(o_reg_write), 32'(e_regw));
    chk("mem_to_reg", 32'(o_mem_to_reg), 32'(e_m2r));
    chk("alu_result", o_alu_result, e_alu);
    chk("rt_rd",      32'(o_rt_rd), 32'(e_rt));
    chk("pc_4",       o_pc_4, e_pc);
    chk("halt",       32'(o_halt), 32'(e_halt));
    chk("error",      32'(o_error), 32'(e_err));
    chk("dbg_data",   o_dbg_data, e_dbg);
    @(negedge clk);
  endtask

  task automatic add(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] er, input logic em, input logic ew);
    vec_t v;
    v.in = mk(rd, wr, sz, uns, addr, wd);
    v.exp_rdata = er; v.exp_mis = em; v.exp_regw = ew;
    tbl.push_back(v);
  endtask

  initial begin
    instr_t t;
    logic [31:0] r1, r2, prev_pc;
    int pat[14] = '{0, 1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    int changes;

    i_valid = 0; i_exec_mode = 0; i_step = 0; i_mem_read = 0; i_mem_write = 0;
    i_mem_size = 0; i_mem_unsigned = 0; i_mem_to_reg = 0; i_reg_write = 0; i_halt = 0;
    i_alu_result = 0; i_write_data = 0; i_rt_rd = 0; i_pc_4 = 0; i_dbg_addr = 0;
    rst = 1'b0;
    model_reset();
    #3 rst = 1'b1;
    #1 chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Known fill: word i = 0x11223300 | i
    for (int i = 0; i < 256; i++) cyc(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'(i * 4), 32'h11223300 | 32'(i)));

    add(0, 1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 0);
    add(1, 0, 2'd2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1);
    add(0, 1, 2'd0, 0, 32'h21,  32'h12345680, 32'h0,        0, 0);
    add(1, 0, 2'd0, 0, 32'h21,  32'h0,        32'hFFFFFF80, 0, 1);
    add(1, 0, 2'd0, 1, 32'h21,  32'h0,        32'h00000080, 0, 1);
    add(1, 0, 2'd0, 0, 32'h20,  32'h0,        32'h00000008, 0, 1);
    add(1, 0, 2'd1, 0, 32'h22,  32'h0,        32'h00001122, 0, 1);
    add(1, 0, 2'd2, 0, 32'h20,  32'h0,        32'h11228008, 0, 1);
    add(0, 1, 2'd1, 0, 32'h13,  32'h00001234, 32'h0,        1, 0);
    add(1, 0, 2'd2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1);
    add(1, 0, 2'd1, 0, 32'h12,  32'h0,        32'hFFFFDEAD, 0, 1);
    add(1, 0, 2'd1, 1, 32'h10,  32'h0,        32'h0000BEEF, 0, 1);
    add(1, 0, 2'd2, 0, 32'h12,  32'h0,        32'h0,        1, 0);
    add(1, 0, 2'd2, 0, 32'h400, 32'h0,        32'h11223300, 0, 1);
    add(1, 1, 2'd2, 0, 32'h404, 32'hCAFEF00D, 32'h0,        0, 1);
    add(1, 0, 2'd3, 0, 32'h4,   32'h0,        32'hCAFEF00D, 0, 1);
    add(1, 0, 2'd0, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0, 1);

    foreach (tbl[i]) begin
      cyc(tbl[i].in);
      chk($sformatf("tbl%0d_rdata", i), o_read_data, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_mis", i), 32'(o_misaligned), 32'(tbl[i].exp_mis));
      chk($sformatf("tbl%0d_regw", i), 32'(o_reg_write), 32'(tbl[i].exp_regw));
    end
    chk("error_sticky", 32'(o_error), 32'h1);

    t = mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    t.dbg = 8'h00;
    cyc(t);
    chk("dbg_alias_word0", o_dbg_data, 32'h11223300);

    // Single-step: a held step advances once, each toggle advances once
    changes = 0;
    prev_pc = o_pc_4;
    for (int k = 0; k < 14; k++) begin
      t = mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      t.mode = 1'b1; t.step = pat[k][0]; t.pc = 32'h1000 + 32'(k);
      cyc(t);
      if (o_pc_4 !== prev_pc) changes++;
      prev_pc = o_pc_4;
      if (k == 6) begin
        chk("step_hold_pc", o_pc_4, 32'h1001);
        chk("step_hold_advances", 32'(changes), 32'd1);
        changes = 0;
      end
    end
    chk("step_toggle_pc", o_pc_4, 32'h100B);
    chk("step_toggle_advances", 32'(changes), 32'd3);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      r1 = $urandom; r2 = $urandom;
      t.v = (r1[2:0] != 3'd0); t.mode = (r1[4:3] == 2'd0); t.step = r1[5];
      t.rd = r1[6]; t.wr = (r1[8:7] == 2'd0); t.sz = r1[10:9]; t.uns = r1[11];
      t.regw = r1[12]; t.halt = r1[13]; t.rt = r1[18:14]; t.dbg = r1[26:19];
      t.addr = r2;
      if (r1[27]) t.addr[1:0] = 2'b00;
      if (r1[30]) t.dbg = t.addr[9:2];
      t.wd = $urandom; t.pc = $urandom;
      cyc(t);
    end

    // Make sure o_error is set, then reset between a step edge and the next clock
    cyc(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h11, 32'h0));
    t = mk(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    t.mode = 1'b1;
    cyc(t);
    i_step = 1'b1;
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_step_reset");
    i_step = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_all_zero("held_reset");
    rst = 1'b0;
    model_reset();
    cyc(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0));
    chk("mem_retained", o_read_data, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
